// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : counter_pkg
// Brief    : Shared state encoding and default constants for countdown_timer.
// Revision : 1.0
// ============================================================================
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int DEFAULT_WIDTH    = 8;
    localparam int DEFAULT_PRESCALE = 1;

    // A prescaler of 1 still keeps a single (always-zero) bit so the
    // counter structure is the same for every legal PRESCALE.
    function automatic int presc_width(input int prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tick_gen
// Brief    : Prescaler producing one decrement tick every PRESCALE enabled cycles.
// Revision : 1.0
// ============================================================================
module tick_gen
    import counter_pkg::*;
#(
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int              PW   = presc_width(PRESCALE);
    localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;

    // With PRESCALE==1, LAST is zero and presc_q never leaves zero, so tick==en.
    assign tick = en && (presc_q == LAST);

    always_comb begin
        presc_d = presc_q;
        if (clr) begin
            presc_d = '0;
        end else if (en) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : countdown_timer
// Brief    : Loadable prescaled down-counter with terminal-count pulse and
//            optional auto-reload.
// Revision : 1.0
// ============================================================================
module countdown_timer
    import counter_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             pause,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic             presc_clr;
    logic             presc_en;
    logic             tick;

    // Kept outside the FSM block so tick never loops back through it.
    // HOLD with pause low resumes and counts on that same edge.
    assign presc_en = !load && !pause && ((state_q == RUN) || (state_q == HOLD));

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (presc_clr),
        .en      (presc_en),
        .tick    (tick)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        tc_d      = 1'b0;
        presc_clr = 1'b0;

        if (load) begin
            count_d   = load_value;
            reload_d  = load_value;
            presc_clr = 1'b1;
            state_d   = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && (count_q != '0)) begin
                        presc_clr = 1'b1;
                        state_d   = RUN;
                    end
                end
                RUN, HOLD: begin
                    if (pause) begin
                        state_d = HOLD;
                    end else begin
                        state_d = RUN;
                        if (tick) begin
                            if (count_q > ONE) begin
                                count_d = count_q - ONE;
                            end else if (count_q == ONE) begin
                                tc_d = 1'b1;
                                if (auto_reload) begin
                                    count_d = reload_q;
                                end else begin
                                    count_d = '0;
                                    state_d = DONE;
                                end
                            end else begin
                                state_d = DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    if (start && (reload_q != '0)) begin
                        count_d   = reload_q;
                        presc_clr = 1'b1;
                        state_d   = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = (state_q == RUN) || (state_q == HOLD);
    assign done  = (state_q == DONE);

endmodule
`default_nettype wire

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counter/timer, the counterpart to the free-running up-counter.
- Counts a programmed value down to zero at a prescaled rate.
- Flags terminal count with a one-cycle pulse, and optionally auto-reloads for periodic operation.
- Serves as a timeout/interval source for control blocks in the same clock domain.

Parameters:
WIDTH, 8, width of count, load_value and reload register
PRESCALE, 1, clock cycles per decrement tick (legal range >= 1)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  reset, synchronous, active-low
load  input  1  load load_value into count and reload register
load_value  input  WIDTH  value captured on load
start  input  1  begin or re-arm counting
pause  input  1  level; freezes count and prescaler while high in RUN/HOLD
auto_reload  input  1  level; 1 = reload on terminal count, 0 = one-shot
count  output  WIDTH  current count value
tc  output  1  one-cycle terminal-count pulse
busy  output  1  high in RUN or HOLD
done  output  1  high in DONE

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (reset_n). All logic updates on the rising edge of clk.
- Reset (reset_n=0 at an edge): count=0, reload_reg=0, prescaler=0, tc=0, state=IDLE, busy=0, done=0. Reset overrides everything, including mid-count.
- Control priority per edge: reset_n > load > start > pause > tick.
- load (any state): count<=load_value, reload_reg<=load_value, prescaler<=0, tc<=0, state<=IDLE. Any simultaneous start is ignored.
- IDLE:
  - start with count!=0 -> RUN, prescaler<=0.
  - start with count==0 -> ignored, stay IDLE.
- RUN:
  - tick = (prescaler==PRESCALE-1) and pause==0. Otherwise prescaler increments.
  - On tick with count>1: count<=count-1.
  - On tick with count==1 and auto_reload=1: count<=reload_reg, tc<=1, stay RUN.
  - On tick with count==1 and auto_reload=0: count<=0, tc<=1, state<=DONE.
  - pause=1 -> HOLD.
- HOLD: count and prescaler frozen; pause=0 -> RUN with the prescaler resuming from its held value.
- DONE:
  - start with reload_reg!=0 -> count<=reload_reg, prescaler<=0, RUN.
  - start with reload_reg==0 -> ignored.
- tc is registered: high for exactly the cycle after the terminal-tick edge, low otherwise. It never asserts twice consecutively unless reload_reg==1 and PRESCALE==1.
- Latency: start sampled at edge E0 -> first decrement at edge E0+PRESCALE. With N loaded, count reaches 0 (or reloads) at edge E0+N*PRESCALE.
- auto_reload is sampled only at the terminal tick.
- No wrap below zero: count never decrements from 0.
- busy = (state==RUN or HOLD); done = (state==DONE). Both are decoded from the state register (glitch-free).

Decomposition:
- Package counter_pkg holds:
  - state enum (IDLE, RUN, HOLD, DONE), 2-bit encoding;
  - default WIDTH and PRESCALE constants.
- One sub-module, tick_gen:
  - prescaler counter of width clog2(PRESCALE) (min 1);
  - inputs clr and en; output tick;
  - PRESCALE==1 yields tick=en.

Test Plan:
- Reset mid-count: load 20, start, hold reset_n=0 for one edge after 5 ticks -> count=0, tc=0, busy=0, done=0 on the following cycle.
- One-shot, PRESCALE=1: load 5, start at E0 -> count 4,3,2,1,0 at E1..E5; tc high exactly one cycle after E5; done=1, busy=0 thereafter; no further change.
- Auto-reload: load 3, auto_reload=1, start -> count 2,1,3,2,1,3…; tc pulses every 3 cycles; done stays 0; busy stays 1.
- Prescale and pause, PRESCALE=4: load 2, start -> first decrement 4 cycles after start. Assert pause for 6 cycles mid-period -> count and prescaler frozen, state HOLD. Release -> remaining prescale cycles resume; terminal at 8+6 cycles.
- Priority: load=1 and start=1 on the same edge with load_value=9 -> count=9, state IDLE, busy=0. start with count=0 -> no state change. Load during RUN -> aborts to IDLE, no tc.
- Re-arm from DONE: after a one-shot of 4 completes, pulse start -> count=4, RUN, terminal again after 4 ticks, tc pulses once.
